// File: rtl/uart_cmd_framer.sv
// Assembles SYNC/opcode/4-data/checksum frames from the UART byte stream into commands.
// Optional inter-byte gap timeout is enabled with `define UART_CMD_FRAMER_TIMEOUT_EN.
module uart_cmd_framer #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         ERR_W          = 8,
    parameter int         TIMEOUT_CYCLES = 43_400
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       byte_in,
    input  logic             byte_in_valid,
    output logic             byte_in_ready,
    output logic [7:0]       cmd_opcode,
    output logic [31:0]      cmd_data,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count
);

    typedef enum logic [2:0] {IDLE, OPCODE, DATA, CHECK, HOLD} state_t;

    typedef struct packed {
        logic [7:0]  opcode;
        logic [31:0] data;
    } cmd_t;

    state_t     state, state_next;
    cmd_t       frame_q;
    cmd_t       cmd_q;
    logic [7:0] csum;
    logic [1:0] idx;
    logic       accept;
    logic       frame_err;
    logic       cmd_load;
    logic       timeout;

    assign byte_in_ready = (state != HOLD);
    assign cmd_valid     = (state == HOLD);
    assign accept        = byte_in_valid && byte_in_ready;
    assign cmd_opcode    = cmd_q.opcode;
    assign cmd_data      = cmd_q.data;

`ifdef UART_CMD_FRAMER_TIMEOUT_EN
    localparam int GAP_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [GAP_W-1:0] gap_cnt;
    logic             in_frame;

    assign in_frame = (state == OPCODE) || (state == DATA) || (state == CHECK);
    // A byte arriving in the expiry cycle wins over the timeout.
    assign timeout  = in_frame && !accept && (gap_cnt == GAP_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            gap_cnt <= '0;
        else if (!in_frame || accept || timeout)
            gap_cnt <= '0;
        else
            gap_cnt <= gap_cnt + GAP_W'(1);
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        frame_err  = 1'b0;
        cmd_load   = 1'b0;
        case (state)
            IDLE:   if (accept && byte_in == SYNC_BYTE) state_next = OPCODE;
            OPCODE: if (accept) state_next = DATA;
            DATA:   if (accept && idx == 2'd3) state_next = CHECK;
            CHECK: begin
                if (accept) begin
                    if (byte_in == csum) begin
                        state_next = HOLD;
                        cmd_load   = 1'b1;
                    end else begin
                        state_next = IDLE;
                        frame_err  = 1'b1;
                    end
                end
            end
            HOLD:    if (cmd_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (timeout) begin
            state_next = IDLE;
            frame_err  = 1'b1;
        end
    end

    // Payload capture; a SYNC value past IDLE is ordinary payload.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_q <= '0;
            csum    <= '0;
            idx     <= '0;
        end else if (accept) begin
            case (state)
                OPCODE: begin
                    frame_q.opcode <= byte_in;
                    csum           <= byte_in;
                    idx            <= '0;
                end
                DATA: begin
                    frame_q.data <= {frame_q.data[23:0], byte_in};
                    csum         <= csum ^ byte_in;
                    idx          <= idx + 2'd1;
                end
                default: ;
            endcase
        end
    end

    // Output copy keeps the last command stable while the next frame is assembled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd_q     <= '0;
            err_pulse <= 1'b0;
            err_count <= '0;
        end else begin
            err_pulse <= frame_err;
            if (cmd_load)
                cmd_q <= frame_q;
            if (frame_err && err_count != {ERR_W{1'b1}})
                err_count <= err_count + ERR_W'(1);
        end
    end

endmodule

// File: tb/tb_uart_cmd_framer.sv
// Directed scoreboard bench for uart_cmd_framer (ERR_W=2, TIMEOUT_CYCLES=20).
module tb_uart_cmd_framer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  byte_in = 8'h00;
    logic        byte_in_valid = 1'b0;
    logic        byte_in_ready;
    logic [7:0]  cmd_opcode;
    logic [31:0] cmd_data;
    logic        cmd_valid;
    logic        cmd_ready = 1'b1;
    logic        err_pulse;
    logic [1:0]  err_count;

    typedef struct packed {
        logic [7:0]  op;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0, fails = 0;
    int   err_seen = 0, exp_err = 0;
    int   cmds_seen = 0, exp_cmds = 0;
    logic prev_err = 1'b0;

    uart_cmd_framer #(.SYNC_BYTE(8'hA5), .ERR_W(2), .TIMEOUT_CYCLES(20)) dut (
        .clk(clk), .reset(reset),
        .byte_in(byte_in), .byte_in_valid(byte_in_valid), .byte_in_ready(byte_in_ready),
        .cmd_opcode(cmd_opcode), .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .err_pulse(err_pulse), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] csum_of(input logic [7:0] op, input logic [31:0] d);
        return op ^ d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0];
    endfunction

    // Scoreboard side: pop on every command handshake, watch error pulses.
    always @(negedge clk) begin
        if (reset) begin
            prev_err = 1'b0;
        end else begin
            if (cmd_valid && cmd_ready) begin
                check("cmd_pending", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("sb_opcode", 64'(cmd_opcode), 64'(e.op));
                    check("sb_data", 64'(cmd_data), 64'(e.data));
                    cmds_seen++;
                end
            end
            if (err_pulse) begin
                err_seen++;
                check("err_pulse_single", 64'(prev_err), 64'd0);
            end
            prev_err = err_pulse;
        end
    end

    // Called right after a posedge (+#1); returns #1 after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        byte_in       = b;
        byte_in_valid = 1'b1;
        @(negedge clk);
        while (!byte_in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("byte_ready", 64'(byte_in_ready), 64'd1);
        @(posedge clk);
        #1;
        byte_in_valid = 1'b0;
    endtask

    task automatic send_body(input logic [7:0] op, input logic [31:0] d, input bit bad);
        logic [7:0] ck;
        ck = csum_of(op, d);
        if (bad) begin
            ck = ck + 8'd1;
            exp_err++;
        end else begin
            exp_q.push_back('{op: op, data: d});
            exp_cmds++;
        end
        send_byte(op);
        for (int i = 3; i >= 0; i--) send_byte(d[i*8 +: 8]);
        send_byte(ck);
    endtask

    task automatic send_frame(input logic [7:0] op, input logic [31:0] d, input bit bad);
        send_byte(8'hA5);
        send_body(op, d, bad);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_valid"}, 64'(cmd_valid), 64'd0);
        check({tag, "_cmd_opcode"}, 64'(cmd_opcode), 64'd0);
        check({tag, "_cmd_data"}, 64'(cmd_data), 64'd0);
        check({tag, "_err_pulse"}, 64'(err_pulse), 64'd0);
        check({tag, "_err_count"}, 64'(err_count), 64'd0);
        check({tag, "_ready"}, 64'(byte_in_ready), 64'd1);
    endtask

    initial begin
        // Reset state
        #12;
        check_reset_outputs("rst");
        @(posedge clk); #1;
        reset = 1'b0;

        // Good frame, one cmd_valid cycle
        send_frame(8'h01, 32'hDEADBEEF, 1'b0);
        check("good_valid", 64'(cmd_valid), 64'd1);
        check("good_opcode", 64'(cmd_opcode), 64'h01);
        check("good_data", 64'(cmd_data), 64'hDEADBEEF);
        check("good_errcnt", 64'(err_count), 64'd0);
        @(posedge clk); #1;
        check("good_valid_drop", 64'(cmd_valid), 64'd0);

        // Bad checksum (24 instead of 23)
        send_frame(8'h01, 32'hDEADBEEF, 1'b1);
        check("bad_err_pulse", 64'(err_pulse), 64'd1);
        check("bad_err_count", 64'(err_count), 64'd1);
        check("bad_no_valid", 64'(cmd_valid), 64'd0);
        @(posedge clk); #1;
        check("bad_err_pulse_end", 64'(err_pulse), 64'd0);
        send_frame(8'h01, 32'hDEADBEEF, 1'b0);
        check("after_bad_valid", 64'(cmd_valid), 64'd1);
        @(posedge clk); #1;

        // Junk before sync is silently dropped
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h5A);
        check("junk_no_err", 64'(err_pulse), 64'd0);
        send_frame(8'h01, 32'hDEADBEEF, 1'b0);
        check("junk_errcnt", 64'(err_count), 64'd1);
        @(posedge clk); #1;

        // Backpressure with the UART offering the next SYNC
        cmd_ready = 1'b0;
        send_frame(8'h5C, 32'hA5A5_0011, 1'b0);
        byte_in       = 8'hA5;
        byte_in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_ready_low", 64'(byte_in_ready), 64'd0);
            check("bp_valid", 64'(cmd_valid), 64'd1);
            check("bp_opcode", 64'(cmd_opcode), 64'h5C);
            check("bp_data", 64'(cmd_data), 64'hA5A5_0011);
            @(posedge clk); #1;
        end
        cmd_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_ready_back", 64'(byte_in_ready), 64'd1);
        @(posedge clk); #1;
        byte_in_valid = 1'b0;
        send_body(8'h01, 32'hDEADBEEF, 1'b0);
        check("bp_next_valid", 64'(cmd_valid), 64'd1);
        @(posedge clk); #1;

        // Error counter saturation at ERR_W=2
        #2 reset = 1'b1;
        #1 check("sat_rst_errcnt", 64'(err_count), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'h10 + 8'(i), 32'h0102_0304, 1'b1);
            check("sat_errcnt", 64'(err_count), 64'((i > 3) ? 3 : i));
        end
        @(posedge clk); #1;

        // Asynchronous reset mid-frame
        send_frame(8'h3C, 32'h1234_5678, 1'b0);
        @(posedge clk); #1;
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'hDE);
        #2 reset = 1'b1;
        #1 check_reset_outputs("midrst");
        @(posedge clk); #1;
        reset = 1'b0;
        send_frame(8'h77, 32'hCAFE_F00D, 1'b0);
        check("midrst_next_valid", 64'(cmd_valid), 64'd1);
        check("midrst_next_data", 64'(cmd_data), 64'hCAFE_F00D);
        @(posedge clk); #1;

`ifdef UART_CMD_FRAMER_TIMEOUT_EN
        // Gap of 20 idle cycles expires the frame
        send_byte(8'hA5);
        send_byte(8'h01);
        repeat (19) @(posedge clk);
        #1 check("to_not_yet", 64'(err_pulse), 64'd0);
        @(posedge clk); #1;
        exp_err++;
        check("to_err_pulse", 64'(err_pulse), 64'd1);
        check("to_err_count", 64'(err_count), 64'd1);
        check("to_idle_ready", 64'(byte_in_ready), 64'd1);
        // Gap of 18 idle cycles is tolerated
        send_byte(8'hA5);
        exp_q.push_back('{op: 8'h01, data: 32'hDEADBEEF});
        exp_cmds++;
        send_byte(8'h01);
        repeat (18) @(posedge clk);
        #1;
        for (int i = 3; i >= 0; i--) send_byte(8'(32'hDEADBEEF >> (i*8)));
        send_byte(8'h23);
        check("gap18_valid", 64'(cmd_valid), 64'd1);
        check("gap18_errcnt", 64'(err_count), 64'd1);
`else
        // Without the timeout a partial frame waits indefinitely
        send_byte(8'hA5);
        exp_q.push_back('{op: 8'h01, data: 32'hDEADBEEF});
        exp_cmds++;
        send_byte(8'h01);
        repeat (25) @(posedge clk);
        #1;
        for (int i = 3; i >= 0; i--) send_byte(8'(32'hDEADBEEF >> (i*8)));
        send_byte(8'h23);
        check("wait_valid", 64'(cmd_valid), 64'd1);
        check("wait_errcnt", 64'(err_count), 64'd0);
`endif
        repeat (3) @(posedge clk);
        #1;

        check("sb_drained", 64'(exp_q.size()), 64'd0);
        check("cmd_total", 64'(cmds_seen), 64'(exp_cmds));
        check("err_total", 64'(err_seen), 64'(exp_err));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
